// File: rtl/stim_pkg.sv
// Shared types and constants for the voting stimulation controller.
// Holds the FSM encoding and the default per-feature detection thresholds.
package stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STIM    = 2'd1,
        ST_REFRACT = 2'd2,
        ST_UNUSED  = 2'd3
    } stim_state_t;

    // Defaults for line length, power spectrum and nonlinear energy channels
    localparam longint TH_LL_DEFAULT = 3000;
    localparam longint TH_PS_DEFAULT = 10000000;
    localparam longint TH_NE_DEFAULT = 250000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/vote_stim_controller_if.sv
// Feature/threshold inputs and decision outputs of the voting stimulation controller.
interface vote_stim_controller_if #(
    parameter int N_CH = 3,
    parameter int DW   = 40
);
    import stim_pkg::*;

    localparam int CW = $clog2(N_CH + 1);

    logic                en;
    logic [N_CH*DW-1:0]  din;
    logic [N_CH-1:0]     data_ready;
    logic [N_CH*DW-1:0]  th;
    logic [CW-1:0]       count;
    logic                win_valid;
    logic                win_drop;
    logic                stimulation;
    stim_state_t         state;

    modport master (
        output en, din, data_ready, th,
        input  count, win_valid, win_drop, stimulation, state
    );

    modport slave (
        input  en, din, data_ready, th,
        output count, win_valid, win_drop, stimulation, state
    );

endinterface

// File: rtl/stim_timer.sv
// Down-counter pacing the STIM and REFRACT phases; done is high while the count is zero.
module stim_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         count,
    output logic         done
);
    logic [W-1:0] remaining;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining <= '0;
        end else if (clear) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_val;
        end else if (count && remaining != '0) begin
            remaining <= remaining - W'(1);
        end
    end

    assign done = (remaining == '0);

endmodule

// File: rtl/vote_stim_controller.sv
// Collects one sample per feature channel, votes K-of-N against thresholds, and
// requests a fixed-length stimulation after PERSIST consecutive positive windows.
module vote_stim_controller
    import stim_pkg::*;
#(
    parameter int N_CH        = 3,
    parameter int DW          = 40,
    parameter int K_VOTE      = 2,
    parameter int PERSIST     = 2,
    parameter int STIM_LEN    = 1000,
    parameter int REFRACT_LEN = 5000,
    parameter int TIMEOUT     = 4096
) (
    input  logic clk,
    input  logic rst,
    vote_stim_controller_if.slave bus
);
    localparam int CW  = $clog2(N_CH + 1);
    localparam int TW  = $clog2(max_int(STIM_LEN, REFRACT_LEN) + 1);
    localparam int TOW = $clog2(TIMEOUT);
    localparam int PW  = $clog2(PERSIST + 1);

    logic signed [DW-1:0] sample [N_CH];
    logic [N_CH-1:0]      flags, flags_d;
    logic [TOW-1:0]       to_cnt, to_cnt_d;
    logic [PW-1:0]        pers, pers_d;
    logic [CW-1:0]        count_q, over_cnt;
    logic                 win_valid_q, win_drop_q, stim_q;
    logic                 all_set, any_set, expire, vote;
    stim_state_t          state_q, state_d;
    logic                 timer_clear, timer_load, timer_done;
    logic [TW-1:0]        timer_val;

    assign all_set = &flags;
    assign any_set = |flags;
    assign expire  = any_set && !all_set && (to_cnt == TOW'(TIMEOUT - 2));

    always_comb begin
        over_cnt = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sample[i] >= $signed(bus.th[i*DW +: DW])) begin
                over_cnt = over_cnt + CW'(1);
            end
        end
    end

    assign vote = (over_cnt >= CW'(K_VOTE));

    // A strobe on the evaluation or drop edge opens the next window
    always_comb begin
        flags_d  = (all_set || expire) ? '0 : flags;
        flags_d  = flags_d | bus.data_ready;
        to_cnt_d = '0;
        if (any_set && !all_set && !expire) begin
            to_cnt_d = to_cnt + TOW'(1);
        end
        if (!bus.en) begin
            flags_d  = '0;
            to_cnt_d = '0;
        end
    end

    always_comb begin
        pers_d = pers;
        if (!bus.en || state_q != ST_IDLE || pers == PW'(PERSIST) || expire) begin
            pers_d = '0;
        end else if (all_set) begin
            pers_d = vote ? pers + PW'(1) : '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_load  = 1'b0;
        timer_val   = '0;
        timer_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pers == PW'(PERSIST)) begin
                    state_d    = ST_STIM;
                    timer_load = 1'b1;
                    timer_val  = TW'(STIM_LEN - 1);
                end
            end
            ST_STIM: begin
                if (timer_done) begin
                    state_d    = ST_REFRACT;
                    timer_load = 1'b1;
                    timer_val  = TW'(REFRACT_LEN - 1);
                end
            end
            ST_REFRACT: begin
                if (timer_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!bus.en) begin
            state_d     = ST_IDLE;
            timer_load  = 1'b0;
            timer_clear = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                sample[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (bus.data_ready[i]) begin
                    sample[i] <= bus.din[i*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags       <= '0;
            to_cnt      <= '0;
            pers        <= '0;
            count_q     <= '0;
            win_valid_q <= 1'b0;
            win_drop_q  <= 1'b0;
            stim_q      <= 1'b0;
            state_q     <= ST_IDLE;
        end else begin
            flags       <= flags_d;
            to_cnt      <= to_cnt_d;
            pers        <= pers_d;
            win_valid_q <= bus.en && all_set;
            win_drop_q  <= bus.en && expire;
            stim_q      <= (state_d == ST_STIM);
            state_q     <= state_d;
            if (bus.en && all_set) begin
                count_q <= over_cnt;
            end
        end
    end

    stim_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (timer_clear),
        .load     (timer_load),
        .load_val (timer_val),
        .count    (state_q == ST_STIM || state_q == ST_REFRACT),
        .done     (timer_done)
    );

    assign bus.count       = count_q;
    assign bus.win_valid   = win_valid_q;
    assign bus.win_drop    = win_drop_q;
    assign bus.stimulation = stim_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_vote_stim_controller.sv
// Directed bench for vote_stim_controller with short stimulation/refractory/timeout lengths.
module tb_vote_stim_controller;
    import stim_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    vote_stim_controller_if #(.N_CH(3), .DW(40)) bus ();

    vote_stim_controller #(
        .N_CH(3), .DW(40), .K_VOTE(2), .PERSIST(2),
        .STIM_LEN(4), .REFRACT_LEN(8), .TIMEOUT(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one set of strobes; returns 1ns after the capturing edge
    task automatic apply_stimulus(input logic [2:0] rdy, input longint ll, input longint ps,
                                  input longint ne);
        bus.din        = {40'(ne), 40'(ps), 40'(ll)};
        bus.data_ready = rdy;
        tick();
        bus.data_ready = '0;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst            = 1'b1;
        bus.en         = 1'b1;
        bus.din        = '0;
        bus.data_ready = '0;
        bus.th         = {40'(TH_NE_DEFAULT), 40'(TH_PS_DEFAULT), 40'(TH_LL_DEFAULT)};
        #12;
        check_output("rst_count", 32'(bus.count), 0);
        check_output("rst_win_valid", 32'(bus.win_valid), 0);
        check_output("rst_win_drop", 32'(bus.win_drop), 0);
        check_output("rst_stim", 32'(bus.stimulation), 0);
        check_output("rst_state", 32'(bus.state), 0);
        rst = 1'b0;
        tick();

        // Two of three at exactly threshold, PS one below
        apply_stimulus(3'b111, 3000, 9999999, 250000);
        tick();
        check_output("w1_count", 32'(bus.count), 2);
        check_output("w1_valid", 32'(bus.win_valid), 1);
        check_output("w1_stim", 32'(bus.stimulation), 0);
        check_output("w1_state", 32'(bus.state), 0);
        tick();
        check_output("w1_valid_pulse", 32'(bus.win_valid), 0);

        // Negative window clears persistence
        apply_stimulus(3'b111, -1, 0, 250000);
        tick();
        check_output("neg_count", 32'(bus.count), 1);
        check_output("neg_valid", 32'(bus.win_valid), 1);

        apply_stimulus(3'b111, 3000, 9999999, 250000);
        tick();
        check_output("w3_count", 32'(bus.count), 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_output("w3_no_stim", 32'(bus.stimulation), 0);
            check_output("w3_idle", 32'(bus.state), 0);
        end

        // Second consecutive positive window triggers stimulation
        apply_stimulus(3'b111, 3000, 9999999, 250000);
        tick();
        check_output("w4_valid", 32'(bus.win_valid), 1);
        check_output("w4_stim_not_yet", 32'(bus.stimulation), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_output("stim_high", 32'(bus.stimulation), 1);
            check_output("stim_state", 32'(bus.state), 1);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            check_output("refract_low", 32'(bus.stimulation), 0);
            check_output("refract_state", 32'(bus.state), 2);
        end
        tick();
        check_output("back_idle", 32'(bus.state), 0);
        check_output("back_idle_stim", 32'(bus.stimulation), 0);

        // Incomplete window times out 15 cycles after the capture edge
        apply_stimulus(3'b011, 5000, 20000000, 0);
        for (int i = 1; i < 15; i++) begin
            tick();
            check_output("no_drop_yet", 32'(bus.win_drop), 0);
        end
        tick();
        check_output("drop_pulse", 32'(bus.win_drop), 1);
        check_output("drop_count_kept", 32'(bus.count), 2);
        check_output("drop_no_valid", 32'(bus.win_valid), 0);
        tick();
        check_output("drop_pulse_end", 32'(bus.win_drop), 0);

        // Flags cleared by the drop, then LL overwritten before completion
        apply_stimulus(3'b100, 0, 0, 0);
        tick();
        check_output("flags_cleared", 32'(bus.win_valid), 0);
        apply_stimulus(3'b001, 2999, 0, 0);
        apply_stimulus(3'b001, 5000, 0, 0);
        apply_stimulus(3'b010, 0, 0, 0);
        apply_stimulus(3'b111, -5, 20000000, 300000);
        check_output("overwrite_count", 32'(bus.count), 1);
        check_output("overwrite_valid", 32'(bus.win_valid), 1);
        tick();
        check_output("eval_edge_count", 32'(bus.count), 2);
        check_output("eval_edge_valid", 32'(bus.win_valid), 1);

        // Asynchronous reset in the middle of a stimulation pulse
        apply_stimulus(3'b111, 3000, 9999999, 250000);
        tick();
        tick();
        tick();
        check_output("pre_rst_stim", 32'(bus.stimulation), 1);
        #3;
        rst = 1'b1;
        #1;
        check_output("async_rst_stim", 32'(bus.stimulation), 0);
        check_output("async_rst_state", 32'(bus.state), 0);
        check_output("async_rst_count", 32'(bus.count), 0);
        #1;
        rst = 1'b0;
        tick();
        check_output("post_rst_stim", 32'(bus.stimulation), 0);

        // Enable dropped mid-refractory
        apply_stimulus(3'b111, 3000, 9999999, 250000);
        tick();
        apply_stimulus(3'b111, 3000, 9999999, 250000);
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
        end
        check_output("mid_refract", 32'(bus.state), 2);
        bus.en = 1'b0;
        tick();
        check_output("en_low_state", 32'(bus.state), 0);
        check_output("en_low_stim", 32'(bus.stimulation), 0);
        check_output("en_low_count", 32'(bus.count), 2);
        bus.en = 1'b1;
        tick();
        tick();
        check_output("en_high_idle", 32'(bus.state), 0);
        check_output("en_high_stim", 32'(bus.stimulation), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
